// File: rtl/wb_serial_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_serial_fifo_if
// Description : Wishbone classic slave bus bundle for wb_serial_fifo.
//               The master modport belongs to the CPU side, and the slave
//               modport belongs to the FIFO bridge.
//               Signals:
//                 wb_adr_i  word address (only [3:0] is decoded by the slave)
//                 wb_dat_i  write data
//                 wb_dat_o  registered read data
//                 wb_we_i   write enable
//                 wb_sel_i  byte lane selects (lane 0 qualifies every write)
//                 wb_ack_o  single-cycle transfer acknowledge
//                 wb_cyc_i  bus cycle
//                 wb_stb_i  strobe
// Revision    : 1.0  initial release
// ============================================================================
interface wb_serial_fifo_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic [AW-1:0]   wb_adr_i;
   logic [DW-1:0]   wb_dat_i;
   logic [DW-1:0]   wb_dat_o;
   logic            wb_we_i;
   logic [DW/8-1:0] wb_sel_i;
   logic            wb_ack_o;
   logic            wb_cyc_i;
   logic            wb_stb_i;

   modport master (
      output wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_cyc_i, wb_stb_i,
      input  wb_dat_o, wb_ack_o
   );

   modport slave (
      input  wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_cyc_i, wb_stb_i,
      output wb_dat_o, wb_ack_o
   );
endinterface
`default_nettype wire

// File: rtl/wb_serial_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_serial_fifo
// Description : Wishbone slave that buffers a byte-stream serial link in both
//               directions. It has a TX FIFO from the CPU to the USB serial
//               core and an RX FIFO from the core to the CPU. It also provides
//               level reporting, an RX threshold interrupt, a sticky TX
//               overflow flag and a flush for each direction.
//
//   Ports:
//     wb_clk_i    sole clock
//     wb_reset_i  asynchronous active-low reset
//     wb          Wishbone slave bundle (wb_serial_fifo_if.slave)
//     tx_data     TX FIFO head byte (show-ahead), toward the host
//     tx_valid    TX FIFO non-empty
//     tx_ready    core accepts tx_data this cycle
//     rx_data     byte from the host
//     rx_valid    rx_data valid
//     rx_ready    RX FIFO not full
//     dtr, rts    host modem lines, reported in ISR
//     irq         level interrupt, |(IER & ISR)
//
//   Register map (word address [3:0]):
//     0 RXDATA  R : [8] byte returned, [7:0] byte, then pops
//     1 TXDATA  W : push [7:0]; dropped and TXOVF set when full
//     2 IER     RW: [7:0]
//     3 ISR     R : {0,0,rts,dtr,TXOVF,rx>=thr,tx empty,rx non-empty}
//               W : bit3 set clears TXOVF
//     4 LEVEL   R : [31:16] TX count, [15:0] RX count
//     5 CTRL    W : bit0 flush RX, bit1 flush TX, [15:8] RX threshold
//               R : threshold in [15:8]
// Revision    : 1.0  initial release
// ============================================================================
module wb_serial_fifo #(
   parameter int AW       = 32,
   parameter int DW       = 32,
   parameter int TX_DEPTH = 64,
   parameter int RX_DEPTH = 64
) (
   input  wire                   wb_clk_i,
   input  wire                   wb_reset_i,
   wb_serial_fifo_if.slave       wb,
   output logic [7:0]            tx_data,
   output logic                  tx_valid,
   input  wire                   tx_ready,
   input  wire  [7:0]            rx_data,
   input  wire                   rx_valid,
   output logic                  rx_ready,
   input  wire                   dtr,
   input  wire                   rts,
   output logic                  irq
);

   // ------------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------------
   localparam int TX_PW = $clog2(TX_DEPTH);
   localparam int TX_CW = TX_PW + 1;
   localparam int RX_PW = $clog2(RX_DEPTH);
   localparam int RX_CW = RX_PW + 1;

   localparam logic [3:0] ADR_RXDATA = 4'd0;
   localparam logic [3:0] ADR_TXDATA = 4'd1;
   localparam logic [3:0] ADR_IER    = 4'd2;
   localparam logic [3:0] ADR_ISR    = 4'd3;
   localparam logic [3:0] ADR_LEVEL  = 4'd4;
   localparam logic [3:0] ADR_CTRL   = 4'd5;

   localparam logic [TX_CW-1:0] TX_FULL_CNT = TX_CW'(TX_DEPTH);
   localparam logic [RX_CW-1:0] RX_FULL_CNT = RX_CW'(RX_DEPTH);

   // The threshold field is 8 bits wide. A deeper RX FIFO can never exceed
   // the programmable range, so the saturation value is capped at 255.
   localparam logic [7:0]  THR_MAX    = (RX_DEPTH > 255) ? 8'hFF : 8'(RX_DEPTH);
   localparam logic [31:0] RX_DEPTH_U = 32'(RX_DEPTH);

   // ------------------------------------------------------------------------
   // Bus decode
   // ------------------------------------------------------------------------
   logic            stb_valid;
   logic            wr_en;
   logic            rd_en;
   logic [3:0]      reg_adr;
   logic [7:0]      thr_wr;
   logic            ack_q;
   logic [DW-1:0]   dat_q;
   logic [DW-1:0]   rd_mux;

   // The ack term keeps a held strobe from being taken twice. This gives
   // back-to-back accesses an alternating ack pattern.
   assign stb_valid = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
   // Byte lane 0 qualifies every register write, not only TXDATA.
   assign wr_en     = stb_valid & wb.wb_we_i & wb.wb_sel_i[0];
   assign rd_en     = stb_valid & ~wb.wb_we_i;
   assign reg_adr   = wb.wb_adr_i[3:0];
   assign thr_wr    = wb.wb_dat_i[15:8];

   assign wb.wb_ack_o = ack_q;
   assign wb.wb_dat_o = dat_q;

   // ------------------------------------------------------------------------
   // Control / status registers
   // ------------------------------------------------------------------------
   logic [7:0] ier;
   logic [7:0] rx_thr;
   logic       tx_ovf;
   logic [7:0] isr;

   // ------------------------------------------------------------------------
   // TX FIFO (bus -> core)
   // ------------------------------------------------------------------------
   logic [7:0]       tx_mem [TX_DEPTH];
   logic [TX_PW-1:0] tx_wr_ptr;
   logic [TX_PW-1:0] tx_rd_ptr;
   logic [TX_CW-1:0] tx_count;
   logic             tx_full;
   logic             tx_wr_req;
   logic             tx_push;
   logic             tx_pop;
   logic             tx_flush;
   logic             tx_ovf_set;

   // Full is judged on the count before this cycle. A bus push that arrives
   // while the FIFO is full is dropped, even when the core pops in the same
   // cycle.
   assign tx_full    = (tx_count == TX_FULL_CNT);
   assign tx_wr_req  = wr_en && (reg_adr == ADR_TXDATA);
   assign tx_push    = tx_wr_req & ~tx_full;
   assign tx_ovf_set = tx_wr_req & tx_full;
   assign tx_pop     = tx_valid & tx_ready;
   assign tx_flush   = wr_en && (reg_adr == ADR_CTRL) && wb.wb_dat_i[1];

   assign tx_valid   = (tx_count != '0);
   assign tx_data    = tx_mem[tx_rd_ptr];

   always_ff @(posedge wb_clk_i) begin
      if (tx_push) begin
         tx_mem[tx_wr_ptr] <= wb.wb_dat_i[7:0];
      end
   end

   // Flush has priority over any push or pop in the same cycle. Returning
   // both pointers to zero discards the FIFO contents.
   always_ff @(posedge wb_clk_i or negedge wb_reset_i) begin
      if (!wb_reset_i) begin
         tx_wr_ptr <= '0;
         tx_rd_ptr <= '0;
         tx_count  <= '0;
      end else if (tx_flush) begin
         tx_wr_ptr <= '0;
         tx_rd_ptr <= '0;
         tx_count  <= '0;
      end else begin
         if (tx_push) begin
            tx_wr_ptr <= tx_wr_ptr + TX_PW'(1);
         end
         if (tx_pop) begin
            tx_rd_ptr <= tx_rd_ptr + TX_PW'(1);
         end
         case ({tx_push, tx_pop})
            2'b10:   tx_count <= tx_count + TX_CW'(1);
            2'b01:   tx_count <= tx_count - TX_CW'(1);
            default: tx_count <= tx_count;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // RX FIFO (core -> bus)
   // ------------------------------------------------------------------------
   logic [7:0]       rx_mem [RX_DEPTH];
   logic [RX_PW-1:0] rx_wr_ptr;
   logic [RX_PW-1:0] rx_rd_ptr;
   logic [RX_CW-1:0] rx_count;
   logic             rx_nonempty;
   logic             rx_push;
   logic             rx_pop;
   logic             rx_flush;
   logic             rx_thr_hit;
   logic [7:0]       rx_head;

   // The RX FIFO cannot overflow. Backpressure is applied at the full count.
   assign rx_ready    = (rx_count != RX_FULL_CNT);
   assign rx_nonempty = (rx_count != '0);
   assign rx_push     = rx_valid & rx_ready;
   assign rx_pop      = rd_en && (reg_adr == ADR_RXDATA) && rx_nonempty;
   assign rx_flush    = wr_en && (reg_adr == ADR_CTRL) && wb.wb_dat_i[0];
   assign rx_head     = rx_mem[rx_rd_ptr];
   assign rx_thr_hit  = (32'(rx_count) >= 32'(rx_thr));

   always_ff @(posedge wb_clk_i) begin
      if (rx_push) begin
         rx_mem[rx_wr_ptr] <= rx_data;
      end
   end

   always_ff @(posedge wb_clk_i or negedge wb_reset_i) begin
      if (!wb_reset_i) begin
         rx_wr_ptr <= '0;
         rx_rd_ptr <= '0;
         rx_count  <= '0;
      end else if (rx_flush) begin
         rx_wr_ptr <= '0;
         rx_rd_ptr <= '0;
         rx_count  <= '0;
      end else begin
         if (rx_push) begin
            rx_wr_ptr <= rx_wr_ptr + RX_PW'(1);
         end
         if (rx_pop) begin
            rx_rd_ptr <= rx_rd_ptr + RX_PW'(1);
         end
         case ({rx_push, rx_pop})
            2'b10:   rx_count <= rx_count + RX_CW'(1);
            2'b01:   rx_count <= rx_count - RX_CW'(1);
            default: rx_count <= rx_count;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Status and interrupt
   // ------------------------------------------------------------------------
   assign isr = {2'b00, rts, dtr, tx_ovf, rx_thr_hit, ~tx_valid, rx_nonempty};
   assign irq = |(ier & isr);

   always_ff @(posedge wb_clk_i or negedge wb_reset_i) begin
      if (!wb_reset_i) begin
         ier    <= 8'h00;
         rx_thr <= 8'h01;
         tx_ovf <= 1'b0;
      end else begin
         if (wr_en && (reg_adr == ADR_IER)) begin
            ier <= wb.wb_dat_i[7:0];
         end
         // A flush does not touch the overflow flag. Only an explicit ISR
         // write with bit 3 set clears it.
         if (tx_ovf_set) begin
            tx_ovf <= 1'b1;
         end else if (wr_en && (reg_adr == ADR_ISR) && wb.wb_dat_i[3]) begin
            tx_ovf <= 1'b0;
         end
         // A threshold of 0 would keep the interrupt asserted on an empty
         // FIFO, so it is stored as 1. Values above the depth could never be
         // reached, so they saturate to the depth.
         if (wr_en && (reg_adr == ADR_CTRL)) begin
            if (thr_wr == 8'h00) begin
               rx_thr <= 8'h01;
            end else if (32'(thr_wr) > RX_DEPTH_U) begin
               rx_thr <= THR_MAX;
            end else begin
               rx_thr <= thr_wr;
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Read mux and bus response
   // ------------------------------------------------------------------------
   // Read data comes from the state before this cycle. An RX byte that
   // arrives in the same cycle as the read is not visible to that read.
   always_comb begin
      rd_mux = '0;
      case (reg_adr)
         ADR_RXDATA: begin
            if (rx_nonempty) begin
               rd_mux[8]   = 1'b1;
               rd_mux[7:0] = rx_head;
            end
         end
         ADR_IER:   rd_mux[7:0]   = ier;
         ADR_ISR:   rd_mux[7:0]   = isr;
         ADR_LEVEL: begin
            rd_mux[15:0]  = 16'(rx_count);
            rd_mux[31:16] = 16'(tx_count);
         end
         ADR_CTRL:  rd_mux[15:8]  = rx_thr;
         default:   rd_mux        = '0;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_reset_i) begin
      if (!wb_reset_i) begin
         ack_q <= 1'b0;
         dat_q <= '0;
      end else begin
         ack_q <= stb_valid;
         if (stb_valid) begin
            dat_q <= wb.wb_we_i ? '0 : rd_mux;
         end
      end
   end

   // Address bits above [3:0], upper data bits and upper byte lanes are not
   // decoded.
   logic unused_bits;
   assign unused_bits = ^{wb.wb_adr_i[AW-1:4], wb.wb_dat_i[DW-1:16],
                          wb.wb_sel_i[DW/8-1:1]};

endmodule
`default_nettype wire

// File: tb/tb_wb_serial_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_serial_fifo
// Description : Self-checking bench for wb_serial_fifo. A queue-based model
//               tracks both FIFOs and the registers. A negedge process
//               compares every DUT output against the model on every cycle.
//               Directed sequences add literal expectations that pin the
//               model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_wb_serial_fifo;

   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int TXD = 64;
   localparam int RXD = 64;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready = 1'b0;
   logic [7:0] rx_data  = 8'h00;
   logic       rx_valid = 1'b0;
   logic       rx_ready;
   logic       dtr = 1'b0;
   logic       rts = 1'b0;
   logic       irq;

   always #5 clk = ~clk;

   wb_serial_fifo_if #(.AW(AW), .DW(DW)) bus ();

   wb_serial_fifo #(.AW(AW), .DW(DW), .TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
      .wb_clk_i   (clk),
      .wb_reset_i (rst_n),
      .wb         (bus),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .dtr        (dtr),
      .rts        (rts),
      .irq        (irq)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------- model
   logic [7:0]  m_tq[$];
   logic [7:0]  m_rq[$];
   logic [7:0]  m_ier;
   logic [7:0]  m_thr;
   logic        m_ovf;
   logic        m_ack;
   logic        m_ack_rd;
   logic [31:0] m_dat;

   function automatic logic [7:0] m_isr();
      logic [7:0] s;
      s    = 8'h00;
      s[0] = (m_rq.size() != 0);
      s[1] = (m_tq.size() == 0);
      s[2] = (m_rq.size() >= int'(m_thr));
      s[3] = m_ovf;
      s[4] = dtr;
      s[5] = rts;
      return s;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_tq.delete();
         m_rq.delete();
         m_ier    = 8'h00;
         m_thr    = 8'h01;
         m_ovf    = 1'b0;
         m_ack    = 1'b0;
         m_ack_rd = 1'b0;
         m_dat    = 32'h0;
      end else begin : model_step
         logic        sv, wr, rd;
         logic [3:0]  a;
         logic [31:0] d;
         logic [7:0]  v;
         int          tn, rn;
         sv = bus.wb_cyc_i && bus.wb_stb_i && !m_ack;
         a  = bus.wb_adr_i[3:0];
         d  = bus.wb_dat_i;
         wr = sv && bus.wb_we_i && bus.wb_sel_i[0];
         rd = sv && !bus.wb_we_i;
         tn = m_tq.size();
         rn = m_rq.size();
         if (rd) begin
            case (a)
               4'd0:    m_dat = (rn > 0) ? (32'h100 | 32'(m_rq[0])) : 32'h0;
               4'd2:    m_dat = 32'(m_ier);
               4'd3:    m_dat = 32'(m_isr());
               4'd4:    m_dat = (32'(tn) << 16) | 32'(rn);
               4'd5:    m_dat = 32'(m_thr) << 8;
               default: m_dat = 32'h0;
            endcase
         end
         m_ack    = sv;
         m_ack_rd = rd;
         if (wr && a == 4'd1 && tn == TXD) m_ovf = 1'b1;
         if (wr && a == 4'd3 && d[3])      m_ovf = 1'b0;
         if (wr && a == 4'd2)              m_ier = d[7:0];
         if (wr && a == 4'd5) begin
            v     = d[15:8];
            m_thr = (v == 8'h00) ? 8'h01 : ((int'(v) > RXD) ? 8'(RXD) : v);
         end
         if (wr && a == 4'd5 && d[1]) m_tq.delete();
         else begin
            if (tn > 0 && tx_ready)            void'(m_tq.pop_front());
            if (wr && a == 4'd1 && tn < TXD)   m_tq.push_back(d[7:0]);
         end
         if (wr && a == 4'd5 && d[0]) m_rq.delete();
         else begin
            if (rd && a == 4'd0 && rn > 0)     void'(m_rq.pop_front());
            if (rx_valid && rn < RXD)          m_rq.push_back(rx_data);
         end
      end
   end

   // ---------------------------------------------------------------- compare
   always @(negedge clk) begin
      if (rst_n) begin
         check("ack", 32'(bus.wb_ack_o), 32'(m_ack));
         if (m_ack && m_ack_rd) check("rdata", bus.wb_dat_o, m_dat);
         check("tx_valid", 32'(tx_valid), 32'(m_tq.size() != 0));
         if (m_tq.size() != 0) check("tx_data", 32'(tx_data), 32'(m_tq[0]));
         check("rx_ready", 32'(rx_ready), 32'(m_rq.size() < RXD));
         check("irq", 32'(irq), 32'(|(m_ier & m_isr())));
      end
   end

   // ---------------------------------------------------------------- tasks
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, output logic [31:0] rdat);
      int n;
      bus.wb_cyc_i = 1'b1;
      bus.wb_stb_i = 1'b1;
      bus.wb_we_i  = we;
      bus.wb_adr_i = adr;
      bus.wb_dat_i = dat;
      bus.wb_sel_i = sel;
      n = 0;
      do begin
         tick(1);
         n++;
      end while (!bus.wb_ack_o && n < 4);
      if (!bus.wb_ack_o) check("ack_timeout", 32'(bus.wb_ack_o), 32'h1);
      rdat = bus.wb_dat_o;
      bus.wb_cyc_i = 1'b0;
      bus.wb_stb_i = 1'b0;
      bus.wb_we_i  = 1'b0;
   endtask

   task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat);
      logic [31:0] dummy;
      wb_xfer(1'b1, adr, dat, 4'hF, dummy);
   endtask

   task automatic wb_read(input logic [31:0] adr, output logic [31:0] rdat);
      wb_xfer(1'b0, adr, 32'h0, 4'hF, rdat);
   endtask

   // ---------------------------------------------------------------- watchdog
   initial begin
      #2_000_000;
      errors++;
      $display("FAIL watchdog simulation time limit reached");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // ---------------------------------------------------------------- stimulus
   logic [31:0] r;
   logic [7:0]  last;
   bit          stop;
   int          seq;
   int          expn;
   int          n;

   initial begin
      bus.wb_cyc_i = 1'b0;
      bus.wb_stb_i = 1'b0;
      bus.wb_we_i  = 1'b0;
      bus.wb_adr_i = '0;
      bus.wb_dat_i = '0;
      bus.wb_sel_i = '0;
      rst_n = 1'b0;
      tick(3);
      check("rst_ack", 32'(bus.wb_ack_o), 32'h0);
      check("rst_dat", bus.wb_dat_o, 32'h0);
      check("rst_tx_valid", 32'(tx_valid), 32'h0);
      check("rst_rx_ready", 32'(rx_ready), 32'h1);
      check("rst_irq", 32'(irq), 32'h0);
      rst_n = 1'b1;
      tick(1);

      wb_read(32'h3, r);  check("isr_reset", r, 32'h2);
      wb_read(32'h4, r);  check("level_reset", r, 32'h0);

      // Three TX bytes are held back and then drained on consecutive cycles.
      wb_write(32'h1, 32'h41);
      wb_write(32'h1, 32'h42);
      wb_write(32'h1, 32'h43);
      wb_read(32'h4, r);  check("level_tx3", r, 32'h0003_0000);
      tx_ready = 1'b1;
      check("tx_seq0", 32'(tx_data), 32'h41);
      tick(1); check("tx_seq1", 32'(tx_data), 32'h42);
      tick(1); check("tx_seq2", 32'(tx_data), 32'h43);
      tick(1); check("tx_drained", 32'(tx_valid), 32'h0);
      tx_ready = 1'b0;
      wb_read(32'h3, r);  check("isr_tx_empty", 32'(r[1]), 32'h1);

      // TX overflow: one byte more than the depth is written.
      for (int i = 0; i <= TXD; i++) wb_write(32'h1, 32'(i));
      wb_read(32'h4, r);  check("level_tx_full", 32'(r[31:16]), 32'(TXD));
      wb_read(32'h3, r);  check("isr_txovf", 32'(r[3]), 32'h1);
      wb_write(32'h3, 32'h08);
      wb_read(32'h3, r);  check("isr_txovf_clr", 32'(r[3]), 32'h0);
      tx_ready = 1'b1;
      last = 8'h00;
      n = 0;
      while (tx_valid && n < TXD + 4) begin
         last = tx_data;
         tick(1);
         n++;
      end
      tx_ready = 1'b0;
      check("tx_drain_count", 32'(n), 32'(TXD));
      check("tx_last_byte", 32'(last), 32'(TXD - 1));

      // RX threshold interrupt.
      wb_write(32'h5, 32'h0400);
      wb_write(32'h2, 32'h04);
      wb_read(32'h5, r);  check("ctrl_thr4", r, 32'h0400);
      for (int i = 0; i < 4; i++) begin
         rx_data  = 8'h10 + 8'(i);
         rx_valid = 1'b1;
         tick(1);
         rx_valid = 1'b0;
         check($sformatf("irq_after_rx%0d", i), 32'(irq), 32'(i == 3));
      end
      wb_read(32'h0, r);  check("rx_pop0", r, 32'h110);
      check("irq_drop", 32'(irq), 32'h0);
      for (int i = 1; i < 4; i++) begin
         wb_read(32'h0, r);
         check($sformatf("rx_pop%0d", i), r, 32'h110 + 32'(i));
      end
      wb_read(32'h0, r);  check("rx_pop_empty", r, 32'h0);

      // Randomized traffic on both FIFOs and all registers.
      stop = 1'b0;
      fork
         begin
            while (!stop) begin
               rx_valid = 1'($urandom_range(0, 1));
               rx_data  = 8'($urandom);
               tx_ready = 1'($urandom_range(0, 1));
               if ($urandom_range(0, 15) == 0) dtr = ~dtr;
               if ($urandom_range(0, 15) == 0) rts = ~rts;
               tick(1);
            end
         end
         begin
            for (int k = 0; k < 400; k++) begin
               logic [31:0] hi;
               logic [31:0] d;
               hi = $urandom & 32'hFFFF_FFF0;
               case ($urandom_range(0, 9))
                  0, 1: wb_read(hi | 32'h0, r);
                  2, 3: wb_write(hi | 32'h1, $urandom);
                  4: begin
                     d = {16'h0, 8'($urandom_range(0, 255)), 8'h00};
                     if ($urandom_range(0, 7) == 0) d[1:0] = 2'($urandom_range(1, 3));
                     wb_write(hi | 32'h5, d);
                  end
                  5: wb_write(hi | 32'h2, $urandom);
                  6: wb_write(hi | 32'h3, $urandom);
                  7: wb_read(hi | 32'($urandom_range(0, 15)), r);
                  8: begin
                     d = {16'h0, 8'($urandom_range(0, 255)), 8'($urandom) & 8'hFC};
                     wb_xfer(1'b1, hi | 32'($urandom_range(0, 15)), d, 4'($urandom), r);
                  end
                  default: wb_read(hi | 32'($urandom_range(3, 4)), r);
               endcase
               if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 3));
            end
            stop = 1'b1;
         end
      join
      rx_valid = 1'b0;
      tx_ready = 1'b0;
      dtr = 1'b0;
      rts = 1'b0;

      // Fill the RX FIFO, then stream through it with pointer wrap.
      wb_write(32'h5, 32'h0103);
      wb_write(32'h2, 32'h00);
      seq = 0;
      rx_data  = 8'h00;
      rx_valid = 1'b1;
      stop = 1'b0;
      fork
         begin
            while (!stop) begin
               logic acc;
               @(negedge clk);
               acc = rx_valid && rx_ready;
               @(posedge clk);
               #1;
               if (acc) begin
                  seq++;
                  rx_data = 8'(seq);
               end
            end
         end
         begin
            tick(RXD + 4);
            check("rx_full_ready", 32'(rx_ready), 32'h0);
            wb_read(32'h4, r);  check("level_rx_full", 32'(r[15:0]), 32'(RXD));
            wb_read(32'h0, r);  check("rx_full_pop", r, 32'h100);
            check("rx_ready_after_pop", 32'(rx_ready), 32'h1);
            expn = 1;
            for (int k = 0; k < 3 * RXD; k++) begin
               wb_read(32'h0, r);
               check("rx_wrap_data", r, 32'h100 | (32'(expn) & 32'hFF));
               expn++;
            end
            wb_read(32'h4, r);  check("level_rx_stream", 32'(r[15:0]), 32'(RXD));
            stop = 1'b1;
         end
      join
      rx_valid = 1'b0;

      // Reset asserted mid-transfer with data in both FIFOs.
      wb_write(32'h5, 32'h0103);
      for (int i = 0; i < 10; i++) wb_write(32'h1, 32'hA0 + 32'(i));
      for (int i = 0; i < 10; i++) begin
         rx_data  = 8'hB0 + 8'(i);
         rx_valid = 1'b1;
         tick(1);
      end
      rx_valid = 1'b0;
      wb_write(32'h2, 32'h03);
      wb_read(32'h4, r);  check("level_pre_rst", r, 32'h000A_000A);
      check("irq_pre_rst", 32'(irq), 32'h1);
      bus.wb_cyc_i = 1'b1;
      bus.wb_stb_i = 1'b1;
      bus.wb_we_i  = 1'b0;
      bus.wb_adr_i = 32'h0;
      n = 0;
      do begin
         tick(1);
         n++;
      end while (!bus.wb_ack_o && n < 4);
      check("ack_pre_rst", 32'(bus.wb_ack_o), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_ack", 32'(bus.wb_ack_o), 32'h0);
      check("async_rst_dat", bus.wb_dat_o, 32'h0);
      check("async_rst_tx_valid", 32'(tx_valid), 32'h0);
      check("async_rst_rx_ready", 32'(rx_ready), 32'h1);
      check("async_rst_irq", 32'(irq), 32'h0);
      bus.wb_cyc_i = 1'b0;
      bus.wb_stb_i = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(1);
      wb_read(32'h4, r);  check("level_post_rst", r, 32'h0);
      wb_read(32'h5, r);  check("ctrl_post_rst", r, 32'h0100);

      tick(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/wb_serial_fifo.md
Name: wb_serial_fifo

Overview:
- Wishbone slave that buffers a byte-stream serial link in both directions.
- Sits between the CPU bus and the USB serial core's byte pipelines.
- Parametrised TX and RX FIFOs replace the single-byte holding register.
- Adds level reporting, an RX threshold interrupt, a sticky TX-overflow flag and per-direction flush.

Parameters:
- AW, 32, Wishbone address width.
- DW, 32, Wishbone data width; must be >= 32.
- TX_DEPTH, 64, TX FIFO depth in bytes; power of 2, >= 2.
- RX_DEPTH, 64, RX FIFO depth in bytes; power of 2, >= 2.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_reset_i  in  1  asynchronous, active-low reset.
- wb_adr_i  in  AW  word address; only [3:0] decoded.
- wb_dat_i  in  DW  write data.
- wb_dat_o  out  DW  read data.
- wb_we_i  in  1  write enable.
- wb_sel_i  in  DW/8  byte selects; lane 0 gates all writes.
- wb_ack_o  out  1  transfer acknowledge.
- wb_cyc_i  in  1  bus cycle.
- wb_stb_i  in  1  strobe.
- tx_data  out  8  head byte of TX FIFO, toward the host.
- tx_valid  out  1  TX FIFO non-empty.
- tx_ready  in  1  core accepts tx_data.
- rx_data  in  8  byte from the host.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  RX FIFO not full.
- dtr  in  1  host DTR.
- rts  in  1  host RTS.
- irq  out  1  level interrupt.

Behaviour:
- Reset (wb_reset_i low, asynchronous): both FIFOs empty; IER=0; RX threshold=1; TXOVF=0; wb_ack_o=0; wb_dat_o=0; tx_valid=0; rx_ready=1; irq=0.
- Bus access:
  - stb_valid = cyc & stb & !ack.
  - wb_ack_o is asserted the cycle after stb_valid, for exactly one cycle. No wait states; back-to-back accesses alternate ack.
  - Side effects (push, pop, clear, flush) occur only on the stb_valid cycle.
- Register map (wb_adr_i[3:0]):
  - 0 RXDATA, read: [7:0] head byte, [8]=1 if a byte was returned, then pops.
    - Empty: returns 0, no pop.
    - Writes ignored.
  - 1 TXDATA, write with sel[0]: pushes wb_dat_i[7:0].
    - Full: byte dropped, TXOVF set.
    - Read returns 0.
  - 2 IER: r/w, [7:0].
  - 3 ISR, read-only status bits:
    - bit0 RX non-empty.
    - bit1 TX empty.
    - bit2 RX count >= threshold.
    - bit3 TXOVF (sticky).
    - bit4 dtr.
    - bit5 rts.
    - bits 7:6 = 0.
    - Write with bit3 set clears TXOVF.
  - 4 LEVEL, read: [15:0] RX count, [31:16] TX count, zero-extended. Count width $clog2(DEPTH)+1, so the full count DEPTH is representable.
  - 5 CTRL:
    - Write: bit0 flushes RX, bit1 flushes TX, [15:8] sets RX threshold. Threshold 0 is stored as 1; values above RX_DEPTH saturate to RX_DEPTH.
    - Read: threshold in [15:8], flush bits read 0.
  - Unmapped addresses: read 0, writes ignored, still acked.
- irq = |(IER & ISR[7:0]), combinational from registered state.
- FIFO rules:
  - Circular buffers with wrapping pointers. Pointer width $clog2(DEPTH); wrap from DEPTH-1 to 0.
  - Show-ahead: tx_data presents the head combinationally.
  - TX pops when tx_valid & tx_ready. RX pushes when rx_valid & rx_ready.
  - Simultaneous push and pop on the same FIFO in one cycle: count unchanged, both take effect, legal even when full or empty.
  - TX full plus a core pop in the same cycle as a bus push: the push is still dropped. Full is evaluated pre-cycle.
  - RX never overflows: rx_ready deasserts at count==RX_DEPTH.
  - Flush in the same cycle as a push or pop on that FIFO: flush wins, count=0 next cycle, the pushed byte is discarded.
  - Flush does not clear TXOVF.
- Read data is registered from pre-pop state. A same-cycle RX push does not affect the returned byte unless the FIFO was empty (returns empty).

Test Plan:
- Reset then read ISR -> 0x02; LEVEL -> 0x00000000; rx_ready=1; tx_valid=0.
- Write TXDATA 0x41, 0x42, 0x43 with tx_ready=0 -> LEVEL[31:16]=3. Raise tx_ready -> tx_data sequence 0x41, 0x42, 0x43 on consecutive cycles, then tx_valid=0 and ISR bit1=1.
- Push TX_DEPTH+1 bytes with tx_ready=0 -> TX count=64, ISR bit3=1, last byte absent. Write ISR 0x08 -> bit3=0.
- Set CTRL threshold 4, IER=0x04; stream 4 RX bytes 0x10..0x13:
  - irq rises after the 4th byte.
  - Reading RXDATA returns 0x110, then irq drops.
  - Reads continue 0x111, 0x112, 0x113, then 0x000.
- Fill RX to RX_DEPTH -> rx_ready=0. Pop once -> rx_ready=1 next cycle. Push and pop in the same cycle at full -> count stays 64. Pointer wrap verified over 3*DEPTH bytes with incrementing data.
- Assert reset mid-transfer with 10 bytes in each FIFO -> all outputs at reset values asynchronously, LEVEL=0 after release.
